mult_seq: RTL and testbench

Sequential radix-2 shift-add multiplier, the multiply-side counterpart of the avg_pool divider. It produces signed (or unsigned) products for scaling pooled sums by fixed-point reciprocals and for requantization. It accepts one operand pair per transaction through a valid/ready handshake. It returns a registered product with a one-cycle valid_out pulse and a saturation/overflow flag.

---
 rtl/mult_pkg.sv | 21 ++
 rtl/mult_abs.sv | 19 +
 rtl/mult_seq.sv | 139 +++++++++++++
 tb/tb_mult_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and default sizing for the sequential shift-add multiplier.
package mult_pkg;

   localparam int unsigned DEF_A_WIDTH   = 32;
   localparam int unsigned DEF_B_WIDTH   = 32;
   localparam int unsigned DEF_OUT_WIDTH = 64;
   localparam bit          DEF_SIGNED    = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Iteration counter width; a one-bit multiplier still needs a one-bit counter.
   function automatic int unsigned cnt_width(input int unsigned b_width);
      return (b_width > 1) ? $clog2(b_width) : 1;
   endfunction

endpackage

// File: rtl/mult_abs.sv
// Splits an operand into unsigned magnitude and sign; the most-negative value maps to 2^(WIDTH-1).
module mult_abs
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_A_WIDTH,
   parameter bit          SIGNED = DEF_SIGNED
) (
   input  logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] magnitude_c,
   output logic             sign_c
);

   // Two's-complement negate when the operand is negative and signed mode is on.
   always_comb begin
      sign_c      = SIGNED ? value[WIDTH-1] : 1'b0;
      magnitude_c = sign_c ? WIDTH'(-value) : value;
   end

endmodule

// File: rtl/mult_seq.sv
// Radix-2 shift-add multiplier with fixed latency, sign fix-up and output saturation.
module mult_seq
   import mult_pkg::*;
#(
   parameter int unsigned A_WIDTH   = DEF_A_WIDTH,
   parameter int unsigned B_WIDTH   = DEF_B_WIDTH,
   parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
   parameter bit          SIGNED    = DEF_SIGNED
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 valid_in,
   output logic                 ready,
   input  logic [A_WIDTH-1:0]   multiplicand,
   input  logic [B_WIDTH-1:0]   multiplier,
   output logic [OUT_WIDTH-1:0] product,
   output logic                 valid_out,
   output logic                 overflow
);

   localparam int unsigned FULL_WIDTH = A_WIDTH + B_WIDTH;
   localparam int unsigned CNT_WIDTH  = cnt_width(B_WIDTH);
   localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(B_WIDTH - 1);

   state_t                state;
   state_t                state_next;
   logic [FULL_WIDTH-1:0] acc;
   logic [FULL_WIDTH-1:0] a_shift;
   logic [B_WIDTH-1:0]    b_reg;
   logic [CNT_WIDTH-1:0]  count;
   logic                  neg;

   logic [A_WIDTH-1:0]    a_mag_c;
   logic                  a_sign_c;
   logic [B_WIDTH-1:0]    b_mag_c;
   logic                  b_sign_c;
   logic                  accept_c;
   logic [FULL_WIDTH-1:0] full_c;
   logic [FULL_WIDTH-1:0] upper_c;
   logic                  fits_c;
   logic [OUT_WIDTH-1:0]  result_c;

   mult_abs #(.WIDTH(A_WIDTH), .SIGNED(SIGNED)) u_abs_a (
      .value       (multiplicand),
      .magnitude_c (a_mag_c),
      .sign_c      (a_sign_c)
   );

   mult_abs #(.WIDTH(B_WIDTH), .SIGNED(SIGNED)) u_abs_b (
      .value       (multiplier),
      .magnitude_c (b_mag_c),
      .sign_c      (b_sign_c)
   );

   assign accept_c = valid_in & ready;

   // Next-state logic: fixed B_WIDTH iterations, then sign fix-up, then a one-cycle result.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept_c) state_next = ITER;
         ITER:    if (count == LAST_COUNT) state_next = FIX;
         FIX:     state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register plus the handshake outputs derived from the upcoming state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         ready     <= 1'b1;
         valid_out <= 1'b0;
      end else begin
         state     <= state_next;
         ready     <= (state_next == IDLE);
         valid_out <= (state_next == DONE);
      end
   end

   // Apply the sign, then check whether the full product fits the output range.
   always_comb begin
      full_c = neg ? FULL_WIDTH'(-acc) : acc;
      if (SIGNED) begin
         upper_c = FULL_WIDTH'($signed(full_c) >>> (OUT_WIDTH - 1));
         fits_c  = (upper_c == '0) || (upper_c == '1);
      end else begin
         upper_c = full_c >> OUT_WIDTH;
         fits_c  = (upper_c == '0);
      end
      if (fits_c) begin
         result_c = OUT_WIDTH'(full_c);
      end else if (!SIGNED) begin
         result_c = '1;
      end else if (neg) begin
         result_c = OUT_WIDTH'(1) << (OUT_WIDTH - 1);
      end else begin
         result_c = ~(OUT_WIDTH'(1) << (OUT_WIDTH - 1));
      end
   end

   // Operand capture, shift-add iterations and result registration.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc      <= '0;
         a_shift  <= '0;
         b_reg    <= '0;
         count    <= '0;
         neg      <= 1'b0;
         product  <= '0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept_c) begin
                  a_shift <= FULL_WIDTH'(a_mag_c);
                  b_reg   <= b_mag_c;
                  neg     <= a_sign_c ^ b_sign_c;
                  acc     <= '0;
                  count   <= '0;
               end
            end
            ITER: begin
               if (b_reg[0]) acc <= acc + a_shift;
               a_shift <= a_shift << 1;
               b_reg   <= b_reg >> 1;
               count   <= count + CNT_WIDTH'(1);
            end
            FIX: begin
               product  <= result_c;
               overflow <= ~fits_c;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: three configurations run in lockstep on shared operands.
module tb_mult_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        valid_in;
   logic [31:0] mcand;
   logic [31:0] mplier;

   logic        rdy_d, rdy_s, rdy_u;
   logic        vo_d, vo_s, vo_u;
   logic        ov_d, ov_s, ov_u;
   logic [63:0] p_d;
   logic [15:0] p_s;
   logic [63:0] p_u;

   int n_vec  = 0;
   int n_fail = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] p_d;
      bit          o_d;
      logic [15:0] p_s;
      bit          o_s;
      logic [63:0] p_u;
      bit          o_u;
   } vec_t;

   mult_seq u_def (
      .clk(clk), .reset(reset), .valid_in(valid_in), .ready(rdy_d),
      .multiplicand(mcand), .multiplier(mplier),
      .product(p_d), .valid_out(vo_d), .overflow(ov_d)
   );

   mult_seq #(.OUT_WIDTH(16)) u_s16 (
      .clk(clk), .reset(reset), .valid_in(valid_in), .ready(rdy_s),
      .multiplicand(mcand), .multiplier(mplier),
      .product(p_s), .valid_out(vo_s), .overflow(ov_s)
   );

   mult_seq #(.SIGNED(1'b0)) u_uns (
      .clk(clk), .reset(reset), .valid_in(valid_in), .ready(rdy_u),
      .multiplicand(mcand), .multiplier(mplier),
      .product(p_u), .valid_out(vo_u), .overflow(ov_u)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Exact product by wide arithmetic, then clamp into the output range.
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                                 input int ow, output logic [63:0] p, output bit ov);
      logic signed [127:0] av, bv, pr, hi, lo, one;
      logic [127:0] pm;
      one = 128'sd1;
      if (sgn) begin
         av = {{96{a[31]}}, a};
         bv = {{96{b[31]}}, b};
         hi = (one <<< (ow - 1)) - one;
         lo = -(one <<< (ow - 1));
      end else begin
         av = {96'd0, a};
         bv = {96'd0, b};
         hi = (one <<< ow) - one;
         lo = '0;
      end
      pr = av * bv;
      ov = 1'b0;
      if (pr > hi) begin
         pr = hi;
         ov = 1'b1;
      end else if (pr < lo) begin
         pr = lo;
         ov = 1'b1;
      end
      pm = pr;
      if (ow < 64) p = 64'(pm) & ((64'd1 << ow) - 64'd1);
      else         p = 64'(pm);
   endfunction

   task automatic start(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      chk("ready_before_accept", 64'({rdy_d, rdy_s, rdy_u}), 64'h7);
      chk("valid_out_idle", 64'({vo_d, vo_s, vo_u}), 64'h0);
      mcand    = a;
      mplier   = b;
      valid_in = 1'b1;
   endtask

   // Wait (bounded) for valid_out; optionally pulse a second pair while busy.
   task automatic finish_txn(input int pulse_at, output int lat,
                             output logic [63:0] pd, output bit od,
                             output logic [15:0] ps, output bit os,
                             output logic [63:0] pu, output bit ou);
      int busy_bad = 0;
      lat = -1;
      pd = '0; od = 1'b0; ps = '0; os = 1'b0; pu = '0; ou = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (k == 1) valid_in = 1'b0;
         if (k == pulse_at) begin
            valid_in = 1'b1;
            mcand    = 32'd11;
            mplier   = 32'd13;
         end
         if (pulse_at > 0 && k == pulse_at + 1) valid_in = 1'b0;
         if (vo_d) begin
            lat = k;
            pd = p_d; od = ov_d; ps = p_s; os = ov_s; pu = p_u; ou = ov_u;
            chk("valid_out_lockstep", 64'({vo_s, vo_u}), 64'h3);
            break;
         end
         if (rdy_d | rdy_s | rdy_u) busy_bad++;
      end
      chk("ready_low_while_busy", 64'(busy_bad), 64'd0);
      chk("latency", 64'(lat), 64'd34);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      logic [63:0] pd, pu;
      logic [15:0] ps;
      bit od, os, ou;
      start(v.a, v.b);
      finish_txn(0, lat, pd, od, ps, os, pu, ou);
      chk($sformatf("%s_prod_s64", tag), pd, v.p_d);
      chk($sformatf("%s_ovf_s64", tag), 64'(od), 64'(v.o_d));
      chk($sformatf("%s_prod_s16", tag), 64'(ps), 64'(v.p_s));
      chk($sformatf("%s_ovf_s16", tag), 64'(os), 64'(v.o_s));
      chk($sformatf("%s_prod_u64", tag), pu, v.p_u);
      chk($sformatf("%s_ovf_u64", tag), 64'(ou), 64'(v.o_u));
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] edges [5];
      edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      case ($urandom_range(0, 3))
         0:       return $urandom;
         1:       return 32'($signed($urandom_range(0, 2000)) - 1000);
         2:       return edges[$urandom_range(0, 4)];
         default: return 32'($urandom_range(0, 65535));
      endcase
   endfunction

   vec_t tbl [12];

   initial begin
      int          lat;
      int          extra;
      logic [63:0] pd, pu, m64;
      logic [15:0] ps;
      bit          od, os, ou, mo;
      vec_t        rv;

      reset    = 1'b0;
      valid_in = 1'b0;
      mcand    = '0;
      mplier   = '0;

      tbl[0]  = '{32'd7,         32'd6,         64'd42,                 1'b0, 16'd42,     1'b0, 64'd42,                 1'b0};
      tbl[1]  = '{32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 16'hFFF1,   1'b0, 64'h4_FFFF_FFF1,        1'b0};
      tbl[2]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFB, 64'd15,                 1'b0, 16'd15,     1'b0, 64'hFFFF_FFF8_0000_000F, 1'b0};
      tbl[3]  = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 16'h7FFF,   1'b1, 64'h4000_0000_0000_0000, 1'b0};
      tbl[4]  = '{32'd300,       32'd300,       64'd90000,              1'b0, 16'h7FFF,   1'b1, 64'd90000,              1'b0};
      tbl[5]  = '{32'hFFFF_FED4, 32'd300,       64'hFFFF_FFFF_FFFE_A070, 1'b0, 16'h8000,   1'b1, 64'h12B_FFFE_A070,      1'b0};
      tbl[6]  = '{32'd100,       32'd100,       64'd10000,              1'b0, 16'd10000,  1'b0, 64'd10000,              1'b0};
      tbl[7]  = '{32'hFFFF_FFFF, 32'd2,         64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 16'hFFFE,   1'b0, 64'h1_FFFF_FFFE,        1'b0};
      tbl[8]  = '{32'd0,         32'hFFFF_FFFF, 64'd0,                  1'b0, 16'd0,      1'b0, 64'd0,                  1'b0};
      tbl[9]  = '{32'd9,         32'd9,         64'd81,                 1'b0, 16'd81,     1'b0, 64'd81,                 1'b0};
      tbl[10] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b0, 16'h7FFF,   1'b1, 64'h3FFF_FFFF_0000_0001, 1'b0};
      tbl[11] = '{32'h8000_0000, 32'd1,         64'hFFFF_FFFF_8000_0000, 1'b0, 16'h8000,   1'b1, 64'h8000_0000,          1'b0};

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_product_s64", p_d, 64'd0);
      chk("rst_product_s16", 64'(p_s), 64'd0);
      chk("rst_product_u64", p_u, 64'd0);
      chk("rst_overflow", 64'({ov_d, ov_s, ov_u}), 64'h0);
      chk("rst_valid_out", 64'({vo_d, vo_s, vo_u}), 64'h0);
      chk("rst_ready", 64'({rdy_d, rdy_s, rdy_u}), 64'h7);
      reset = 1'b1;

      // Directed table; consecutive entries also exercise back-to-back accepts.
      for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

      // Second pair offered while busy must be dropped; result then holds.
      start(32'd5, 32'd7);
      finish_txn(10, lat, pd, od, ps, os, pu, ou);
      chk("busy_prod_s64", pd, 64'd35);
      chk("busy_prod_s16", 64'(ps), 64'd35);
      extra = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (vo_d | vo_s | vo_u) extra++;
      end
      chk("busy_no_second_result", 64'(extra), 64'd0);
      chk("busy_product_held", p_d, 64'd35);

      // Reset during ITER aborts the transaction.
      start(32'd123, 32'd456);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) valid_in = 1'b0;
      end
      reset = 1'b0;
      #1;
      chk("midrst_product", p_d, 64'd0);
      chk("midrst_overflow", 64'({ov_d, ov_s, ov_u}), 64'h0);
      chk("midrst_ready", 64'({rdy_d, rdy_s, rdy_u}), 64'h7);
      @(negedge clk);
      reset = 1'b1;
      extra = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (vo_d | vo_s | vo_u) extra++;
      end
      chk("midrst_no_result", 64'(extra), 64'd0);
      run_vec(tbl[9], "after_rst");

      // Randomized operands against the arithmetic model.
      for (int i = 0; i < 30; i++) begin
         rv.a = pick_operand();
         rv.b = pick_operand();
         model(rv.a, rv.b, 1'b1, 64, m64, mo); rv.p_d = m64; rv.o_d = mo;
         model(rv.a, rv.b, 1'b1, 16, m64, mo); rv.p_s = 16'(m64); rv.o_s = mo;
         model(rv.a, rv.b, 1'b0, 64, m64, mo); rv.p_u = m64; rv.o_u = mo;
         run_vec(rv, $sformatf("rnd%0d_%h_%h", i, rv.a, rv.b));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
